// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if
//   Bundles the control strobes, the serial ADC pins and the deserialised
//   result of the current-sense ADC front end.
//   master : the SPI reader (drives chip select, SCLK and the result)
//   slave  : the surrounding logic / ADC (drives enable, clear_fail, sdo)
//   Signals:
//     enable          run periodic conversions
//     clear_fail      one-cycle strobe clearing adc_frame_error
//     adc_cs_n        ADC chip select, active low
//     adc_sclk        ADC serial clock, idles low
//     adc_sdo         ADC serial data, MSB first
//     adc_data_valid  one-cycle strobe qualifying adc_data
//     adc_data        last good result, right-justified, zero-extended
//     adc_frame_error sticky flag: a lead bit was non-zero
//     adc_busy        high while adc_cs_n is low
interface adc_spi_reader_if;
  logic        enable;
  logic        clear_fail;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_sdo;
  logic        adc_data_valid;
  logic [15:0] adc_data;
  logic        adc_frame_error;
  logic        adc_busy;

  modport master (
    input  enable, clear_fail, adc_sdo,
    output adc_cs_n, adc_sclk, adc_data_valid, adc_data, adc_frame_error, adc_busy
  );

  modport slave (
    output enable, clear_fail, adc_sdo,
    input  adc_cs_n, adc_sclk, adc_data_valid, adc_data, adc_frame_error, adc_busy
  );
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader
//   SPI master for the serial current-sense ADC. Runs one conversion frame
//   every P clk cycles while enabled, shifts in LEAD_BITS + DATA_BITS bits
//   MSB first and presents the result as a one-cycle valid/data pair.
//   Frames whose lead bits are not all zero are dropped and raise a sticky
//   error, cleared by clear_fail (a coincident set wins).
//   Ports:
//     clk   system clock
//     rstn  asynchronous active-low reset
//     bus   adc_spi_reader_if.master (control, SPI pins, result)
module adc_spi_reader #(
  parameter int CLK_DIV     = 4,   // SCLK half-period in clk cycles, >= 2
  parameter int LEAD_BITS   = 2,   // leading zero bits before data, 0..4
  parameter int DATA_BITS   = 16,  // result width, 12..16
  parameter int CONV_PERIOD = 200  // clk cycles between chip-select falls
) (
  input  logic             clk,
  input  logic             rstn,
  adc_spi_reader_if.master bus
);

  localparam int N  = LEAD_BITS + DATA_BITS;
  localparam int F  = CLK_DIV * (2 * N + 1);
  // The period can never be shorter than a frame plus one half-period of
  // chip-select high time.
  localparam int P  = (CONV_PERIOD > F + CLK_DIV) ? CONV_PERIOD : F + CLK_DIV;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(N);
  localparam int PW = $clog2(P);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, END, GAP} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   div_reg, div_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic [PW-1:0]   per_reg, per_next;
  logic [N-1:0]    shift_reg, shift_next;
  logic            cs_n_reg, cs_n_next;
  logic            sclk_reg, sclk_next;
  logic            busy_reg, busy_next;
  logic            valid_reg, valid_next;
  logic [15:0]     data_reg, data_next;
  logic            err_reg, err_next;

  logic            half_tick;
  logic            lead_bad;
  logic            start;

  // One pulse every CLK_DIV cycles, phase-locked to the chip-select fall.
  assign half_tick = (div_reg == DW'(CLK_DIV - 1));
  // Lead bits sit above the data bits in the shift register; with no lead
  // bits the shift leaves nothing and the frame is always good.
  assign lead_bad  = |(shift_reg >> DATA_BITS);

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    per_next   = per_reg;
    shift_next = shift_reg;
    cs_n_next  = cs_n_reg;
    sclk_next  = sclk_reg;
    busy_next  = busy_reg;
    valid_next = 1'b0;
    data_next  = data_reg;
    err_next   = err_reg;
    start      = 1'b0;

    if (bus.clear_fail) begin
      err_next = 1'b0;
    end

    // Period counter holds the number of edges since the last cs_n fall.
    if (state_reg != IDLE) begin
      per_next = per_reg + 1'b1;
    end

    if (state_reg == SETUP || state_reg == SHIFT || state_reg == END) begin
      div_next = half_tick ? '0 : div_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          start = 1'b1;
        end
      end
      SETUP: begin
        if (half_tick) begin
          sclk_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (half_tick) begin
          if (sclk_reg) begin
            // Falling SCLK edge: sample the bit that has been stable for
            // the whole high half-period.
            sclk_next  = 1'b0;
            shift_next = {shift_reg[N-2:0], bus.adc_sdo};
            if (bit_reg == BW'(N - 1)) begin
              state_next = END;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            sclk_next = 1'b1;
          end
        end
      end
      END: begin
        // Trailing half-period with SCLK low, then release chip select and
        // publish the result.
        if (half_tick) begin
          cs_n_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = GAP;
          if (lead_bad) begin
            err_next = 1'b1;
          end else begin
            valid_next = 1'b1;
            data_next  = 16'(shift_reg[DATA_BITS-1:0]);
          end
        end
      end
      GAP: begin
        if (per_reg == PW'(P - 1)) begin
          if (bus.enable) begin
            start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (start) begin
      state_next = SETUP;
      cs_n_next  = 1'b0;
      busy_next  = 1'b1;
      sclk_next  = 1'b0;
      per_next   = '0;
      div_next   = '0;
      bit_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      per_reg   <= '0;
      shift_reg <= '0;
      cs_n_reg  <= 1'b1;
      sclk_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      per_reg   <= per_next;
      shift_reg <= shift_next;
      cs_n_reg  <= cs_n_next;
      sclk_reg  <= sclk_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  assign bus.adc_cs_n        = cs_n_reg;
  assign bus.adc_sclk        = sclk_reg;
  assign bus.adc_busy        = busy_reg;
  assign bus.adc_data_valid  = valid_reg;
  assign bus.adc_data        = data_reg;
  assign bus.adc_frame_error = err_reg;

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader
//   dut_a: default parameters (F = 148, P = 200): nominal, lead error,
//          clear_fail, enable drop, mid-frame reset.
//   dut_b: CONV_PERIOD = 100 (P = 152): short period.
//   dut_c: LEAD_BITS = 0, DATA_BITS = 12, CONV_PERIOD = 100 (F = 100).
//   Stimulus pushes one expected record per dut_a frame; the monitor pops
//   it when chip select rises and compares.
module tb_adc_spi_reader;

  typedef struct {
    int          start;  // absolute cycle of the cs_n fall, 0 = don't care
    int          len;    // cycles from cs_n fall to cs_n rise
    int          rises;  // SCLK rising edges inside the frame
    logic        valid;
    logic [15:0] data;
    logic        err;
    int          gap;    // cycles to the next cs_n fall, 0 = don't care
  } exp_t;

  logic clk = 1'b0;
  logic rstn_a = 1'b1;
  logic rstn_bc = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   tmo = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  exp_t q_a[$];
  exp_t e_a;

  logic [17:0] word_a = '0;
  logic [17:0] word_b = {2'b00, 16'h5A5A};
  logic [11:0] word_c = 12'hABC;
  int idx_a = 0, idx_b = 0, idx_c = 0;
  logic psa = 1'b0, psb = 1'b0, psc = 1'b0;

  adc_spi_reader_if ifa ();
  adc_spi_reader_if ifb ();
  adc_spi_reader_if ifc ();

  adc_spi_reader dut_a (.clk(clk), .rstn(rstn_a), .bus(ifa.master));
  adc_spi_reader #(.CONV_PERIOD(100)) dut_b (.clk(clk), .rstn(rstn_bc), .bus(ifb.master));
  adc_spi_reader #(.LEAD_BITS(0), .DATA_BITS(12), .CONV_PERIOD(100)) dut_c (
    .clk(clk), .rstn(rstn_bc), .bus(ifc.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: present bit idx while SCLK is high, advance after each SCLK fall.
  assign ifa.adc_sdo = (idx_a < 18) ? word_a[5'(17 - idx_a)] : 1'b0;
  assign ifb.adc_sdo = (idx_b < 18) ? word_b[5'(17 - idx_b)] : 1'b0;
  assign ifc.adc_sdo = (idx_c < 12) ? word_c[4'(11 - idx_c)] : 1'b0;

  always @(negedge clk) begin
    psa <= ifa.adc_sclk;
    psb <= ifb.adc_sclk;
    psc <= ifc.adc_sclk;
    if (ifa.adc_cs_n !== 1'b0) idx_a <= 0;
    else if (psa && !ifa.adc_sclk) idx_a <= idx_a + 1;
    if (ifb.adc_cs_n !== 1'b0) idx_b <= 0;
    else if (psb && !ifb.adc_sclk) idx_b <= idx_b + 1;
    if (ifc.adc_cs_n !== 1'b0) idx_c <= 0;
    else if (psc && !ifc.adc_sclk) idx_c <= idx_c + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic csa_prev = 1'b1, sca_prev = 1'b0, csb_prev = 1'b1, csc_prev = 1'b1;
  int   fall_a = 0, rises_a = 0, gap_exp_a = 0;
  logic vchk_a = 1'b0;
  int   fall_b = 0, rise_b = 0, frames_b = 0;
  int   fall_c = 0, frames_c = 0;

  always @(negedge clk) begin
    if (cyc == 2) begin
      check("rst_cs_n", ifa.adc_cs_n, 1);
      check("rst_sclk", ifa.adc_sclk, 0);
      check("rst_valid", ifa.adc_data_valid, 0);
      check("rst_data", ifa.adc_data, 0);
      check("rst_err", ifa.adc_frame_error, 0);
      check("rst_busy", ifa.adc_busy, 0);
    end
    if (cyc == 20) check("idle_no_enable", ifa.adc_cs_n, 1);

    // dut_a
    if (ifa.adc_cs_n == 1'b0 && csa_prev) begin
      if (gap_exp_a != 0) check("a_period", cyc - fall_a, gap_exp_a);
      if (q_a.size() > 0 && q_a[0].start != 0) check("a_start", cyc, q_a[0].start);
      check("a_busy_rise", ifa.adc_busy, 1);
      fall_a = cyc;
      rises_a = 0;
    end
    if (ifa.adc_sclk && !sca_prev) rises_a++;
    if (ifa.adc_cs_n == 1'b1 && !csa_prev) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_frame", 1, 0);
      end else begin
        e_a = q_a.pop_front();
        check("a_frame_len", cyc - fall_a, e_a.len);
        check("a_sclk_rises", rises_a, e_a.rises);
        check("a_valid", ifa.adc_data_valid, int'(e_a.valid));
        check("a_data", ifa.adc_data, int'(e_a.data));
        check("a_err", ifa.adc_frame_error, int'(e_a.err));
        check("a_busy_fall", ifa.adc_busy, 0);
        gap_exp_a = e_a.gap;
        vchk_a = 1'b1;
      end
    end else if (vchk_a) begin
      check("a_valid_one_cycle", ifa.adc_data_valid, 0);
      vchk_a = 1'b0;
    end else if (ifa.adc_data_valid === 1'b1) begin
      check("a_stray_valid", 1, 0);
    end
    csa_prev = ifa.adc_cs_n;
    sca_prev = ifa.adc_sclk;

    // dut_b: short period
    if (ifb.adc_cs_n == 1'b0 && csb_prev) begin
      if (frames_b >= 1 && frames_b <= 4) begin
        check("b_period", cyc - fall_b, 152);
        check("b_cs_high", cyc - rise_b, 4);
      end
      fall_b = cyc;
      frames_b++;
    end
    if (ifb.adc_cs_n == 1'b1 && !csb_prev) rise_b = cyc;
    if (ifb.adc_data_valid === 1'b1 && frames_b <= 4) check("b_data", ifb.adc_data, 16'h5A5A);
    csb_prev = ifb.adc_cs_n;

    // dut_c: 12-bit, no lead bits
    if (ifc.adc_cs_n == 1'b0 && csc_prev) begin
      fall_c = cyc;
      frames_c++;
    end
    if (ifc.adc_data_valid === 1'b1 && frames_c <= 3) begin
      check("c_data", ifc.adc_data, 16'h0ABC);
      check("c_valid_edge", cyc - fall_c, 100);
    end
    csc_prev = ifc.adc_cs_n;

    if (end_req && !end_done) begin
      check("a_frames_left", q_a.size(), 0);
      check("a_idle_after_disable", ifa.adc_cs_n, 1);
      check("b_frames_seen", int'(frames_b >= 5), 1);
      check("c_frames_seen", int'(frames_c >= 4), 1);
      check("wait_timeouts", tmo, 0);
      end_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  int t0 = 0;

  task automatic wait_fall();
    logic prev;
    prev = ifa.adc_cs_n;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ifa.adc_cs_n == 1'b0 && prev == 1'b1) begin
        t0 = cyc;
        return;
      end
      prev = ifa.adc_cs_n;
    end
    tmo++;
    t0 = cyc;
  endtask

  // Returns at the negedge following edge n of the current frame, so a
  // value driven here is sampled at edge n+1.
  task automatic wait_rel(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic next_frame(input logic [17:0] w, input exp_t e);
    word_a = w;
    q_a.push_back(e);
    $display("frame: word=%05h expect len=%0d valid=%0b data=%04h err=%0b",
             w, e.len, e.valid, e.data, e.err);
    wait_fall();
  endtask

  task automatic pulse_clear();
    ifa.clear_fail = 1'b1;
    @(negedge clk);
    ifa.clear_fail = 1'b0;
  endtask

  initial begin
    ifa.enable = 1'b0; ifa.clear_fail = 1'b0;
    ifb.enable = 1'b0; ifb.clear_fail = 1'b0;
    ifc.enable = 1'b0; ifc.clear_fail = 1'b0;
    #1;
    rstn_a = 1'b0;
    rstn_bc = 1'b0;
    repeat (4) @(negedge clk);
    rstn_a = 1'b1;
    rstn_bc = 1'b1;
    ifb.enable = 1'b1;
    ifc.enable = 1'b1;
    while (cyc < 30) @(negedge clk);

    // Nominal frame; enable sampled at edge 31 starts it on that edge.
    ifa.enable = 1'b1;
    next_frame({2'b00, 16'hA5C3}, '{31, 148, 18, 1'b1, 16'hA5C3, 1'b0, 200});
    wait_rel(170);

    // Lead error, then clear_fail at edge 160.
    next_frame({2'b01, 16'h1234}, '{0, 148, 18, 1'b0, 16'hA5C3, 1'b1, 200});
    wait_rel(159);
    pulse_clear();
    wait_rel(170);

    // Good frame: error must be cleared by now.
    next_frame({2'b00, 16'h0F0F}, '{0, 148, 18, 1'b1, 16'h0F0F, 1'b0, 200});
    wait_rel(170);

    // Lead error with clear_fail on the same edge: set wins.
    next_frame({2'b10, 16'hFFFF}, '{0, 148, 18, 1'b0, 16'h0F0F, 1'b1, 200});
    wait_rel(147);
    pulse_clear();
    wait_rel(160);
    pulse_clear();
    wait_rel(170);

    // Enable drop at edge 50; frame completes, re-enable sampled at edge 301.
    next_frame({2'b00, 16'h8001}, '{0, 148, 18, 1'b1, 16'h8001, 1'b0, 301});
    wait_rel(49);
    ifa.enable = 1'b0;
    wait_rel(300);
    ifa.enable = 1'b1;

    // Reset at edge 80, released so that edge 91 starts a fresh frame.
    next_frame({2'b00, 16'h7E55}, '{0, 80, 10, 1'b0, 16'h0000, 1'b0, 91});
    wait_rel(79);
    @(posedge clk);
    #1 rstn_a = 1'b0;
    wait_rel(90);
    rstn_a = 1'b1;

    // First frame after reset yields correct data; then stop.
    next_frame({2'b00, 16'h3C96}, '{0, 148, 18, 1'b1, 16'h3C96, 1'b0, 0});
    wait_rel(170);
    ifa.enable = 1'b0;
    wait_rel(260);

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
